// File: rtl/bit_count_unit.sv
// bit_count_unit: multi-cycle ones/zeros/CLZ/CTZ counter examining CHUNK bits per cycle
module bit_count_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    localparam int RW = $clog2(WIDTH + 1),
    localparam int NCH = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    result
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(CHUNK + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] op, op_n;
    logic [1:0]       md, md_n;
    logic [RW-1:0]    acc, acc_n, res_n;
    logic [IW-1:0]    idx, idx_n, sel;
    logic             found, found_n, done_n;
    logic [CHUNK-1:0] chunk;
    logic [CW-1:0]    ones, lz, tz;
    logic             hit_l, hit_t;

    assign busy = (state == RUN);

    // CLZ walks the operand from the top chunk down; every other mode walks up from bit 0
    always_comb begin
        sel = (md == 2'b10) ? IW'(NCH - 1) - idx : idx;
        chunk = '0;
        for (int k = 0; k < NCH; k++)
            if (IW'(k) == sel) chunk = op[k*CHUNK +: CHUNK];
    end

    // Population count plus leading/trailing zero counts of the current chunk
    always_comb begin
        ones = '0;
        lz = '0;
        tz = '0;
        hit_l = 1'b0;
        hit_t = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + CW'(chunk[i]);
            tz = tz + CW'(!hit_t && !chunk[i]);
            hit_t = hit_t | chunk[i];
            lz = lz + CW'(!hit_l && !chunk[CHUNK-1-i]);
            hit_l = hit_l | chunk[CHUNK-1-i];
        end
    end

    // Next-state logic: latch on start, accumulate one chunk per RUN cycle, publish on the last one
    always_comb begin
        state_n = state;
        op_n = op;
        md_n = md;
        acc_n = acc;
        idx_n = idx;
        found_n = found;
        res_n = result;
        done_n = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n = RUN;
                op_n = data;
                md_n = mode;
                acc_n = '0;
                idx_n = '0;
                found_n = 1'b0;
            end
        end else begin
            acc_n = (md == 2'b00) ? acc + RW'(ones) :
                    (md == 2'b01) ? acc + RW'(CW'(CHUNK) - ones) :
                    found         ? acc :
                                    acc + RW'(md[0] ? tz : lz);
            found_n = found | (|chunk);
            idx_n = idx + IW'(1);
            if (idx == IW'(NCH - 1)) begin
                state_n = IDLE;
                idx_n = '0;
                res_n = acc_n;
                done_n = 1'b1;
            end
        end
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op <= '0;
            md <= '0;
            acc <= '0;
            idx <= '0;
            found <= 1'b0;
            result <= '0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            op <= op_n;
            md <= md_n;
            acc <= acc_n;
            idx <= idx_n;
            found <= found_n;
            result <= res_n;
            done <= done_n;
        end
    end
endmodule

// File: tb/tb_bit_count_unit.sv
// tb_bit_count_unit: directed checks of bit_count_unit at CHUNK=8, 1 and 32
module tb_bit_count_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  st;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        bz [3];
    logic        dn [3];
    logic [5:0]  res [3];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc;
    int          seen;

    always #5 clk = ~clk;

    bit_count_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(st[0]), .mode(mode), .data(data),
        .busy(bz[0]), .done(dn[0]), .result(res[0]));
    bit_count_unit #(.WIDTH(32), .CHUNK(1)) dut_c1 (
        .clk(clk), .reset(reset), .start(st[1]), .mode(mode), .data(data),
        .busy(bz[1]), .done(dn[1]), .result(res[1]));
    bit_count_unit #(.WIDTH(32), .CHUNK(32)) dut_c32 (
        .clk(clk), .reset(reset), .start(st[2]), .mode(mode), .data(data),
        .busy(bz[2]), .done(dn[2]), .result(res[2]));

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int u);
        cyc = 0;
        while (bz[u] === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run(input int u, input logic [1:0] m, input logic [31:0] d,
                       input int exp, input int nch, input string tag);
        @(negedge clk);
        st[u] = 1'b1;
        mode = m;
        data = d;
        @(negedge clk);
        st[u] = 1'b0;
        check({tag, "_busy"}, int'(bz[u]), 1);
        wait_done(u);
        check({tag, "_cycles"}, cyc, nch);
        check({tag, "_done"}, int'(dn[u]), 1);
        check({tag, "_result"}, int'(res[u]), exp);
        @(negedge clk);
        check({tag, "_done_drop"}, int'(dn[u]), 0);
        check({tag, "_result_hold"}, int'(res[u]), exp);
    endtask

    initial begin
        reset = 1'b1;
        st = '0;
        mode = '0;
        data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bz[0]), 0);
        check("rst_done", int'(dn[0]), 0);
        check("rst_result", int'(res[0]), 0);
        reset = 1'b0;
        run(0, 2'b00, 32'hFFFF_FFFF, 32, 4, "ones_all");
        run(0, 2'b00, 32'h8000_0001, 2, 4, "ones_ends");
        run(0, 2'b01, 32'h0000_00F0, 28, 4, "zeros_f0");
        run(0, 2'b01, 32'h0000_0000, 32, 4, "zeros_zero");
        run(0, 2'b10, 32'h0001_0000, 15, 4, "clz_bit16");
        run(0, 2'b10, 32'h0000_0000, 32, 4, "clz_zero");
        run(0, 2'b10, 32'h8000_0000, 0, 4, "clz_msb");
        run(0, 2'b10, 32'hFFFF_FFFF, 0, 4, "clz_ones");
        run(0, 2'b11, 32'h8000_0000, 31, 4, "ctz_msb");
        run(0, 2'b11, 32'h0000_0100, 8, 4, "ctz_bit8");
        run(0, 2'b11, 32'h0000_0000, 32, 4, "ctz_zero");
        run(0, 2'b11, 32'hFFFF_FFFF, 0, 4, "ctz_ones");
        // start while busy must not disturb the latched operand nor queue a request
        @(negedge clk);
        st[0] = 1'b1;
        mode = 2'b00;
        data = 32'h0000_000F;
        @(negedge clk);
        data = 32'hFFFF_FFFF;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0);
        check("ign_cycles", cyc, 3);
        check("ign_done", int'(dn[0]), 1);
        check("ign_result", int'(res[0]), 4);
        @(negedge clk);
        check("ign_no_queue", int'(bz[0]), 0);
        // back-to-back: start raised in the done cycle is accepted
        @(negedge clk);
        st[0] = 1'b1;
        mode = 2'b00;
        data = 32'h0000_0007;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0);
        check("b2b_first_result", int'(res[0]), 3);
        check("b2b_first_done", int'(dn[0]), 1);
        st[0] = 1'b1;
        mode = 2'b11;
        data = 32'h0000_0010;
        @(negedge clk);
        st[0] = 1'b0;
        check("b2b_busy", int'(bz[0]), 1);
        wait_done(0);
        check("b2b_cycles", cyc, 4);
        check("b2b_result", int'(res[0]), 4);
        // asynchronous reset in the second RUN cycle
        @(negedge clk);
        st[0] = 1'b1;
        mode = 2'b00;
        data = 32'hFFFF_FFFF;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", int'(bz[0]), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", int'(bz[0]), 0);
        check("arst_done", int'(dn[0]), 0);
        check("arst_result", int'(res[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (dn[0] === 1'b1 || bz[0] === 1'b1) seen++;
        end
        check("arst_no_done", seen, 0);
        run(1, 2'b10, 32'h0001_0000, 15, 32, "c1_clz_bit16");
        run(1, 2'b10, 32'h0000_0000, 32, 32, "c1_clz_zero");
        run(1, 2'b10, 32'h8000_0000, 0, 32, "c1_clz_msb");
        run(2, 2'b10, 32'h0001_0000, 15, 1, "c32_clz_bit16");
        run(2, 2'b10, 32'h0000_0000, 32, 1, "c32_clz_zero");
        run(2, 2'b10, 32'h8000_0000, 0, 1, "c32_clz_msb");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_count_unit.md
Name: bit_count_unit

Overview:
- Multi-cycle, parametrised bit-statistics unit.
- Computes one of four counts on a WIDTH-bit operand: ones, zeros, leading zeros or trailing zeros.
- Processes CHUNK bits per cycle under a start/busy/done handshake.
- Sits beside the MDU in the EX stage; the stall logic holds the pipeline while busy is high and takes the result into the writeback path on done.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits examined per cycle; 1 <= CHUNK <= WIDTH.
- RW (localparam), $clog2(WIDTH+1), result width; must hold the value WIDTH.
- NCH (localparam), WIDTH/CHUNK, number of processing cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled only when busy=0.
- mode  input  2  operation select: 00 count ones, 01 count zeros, 10 count leading zeros (CLZ), 11 count trailing zeros (CTZ).
- data  input  WIDTH  operand; sampled together with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  RW  count of the last completed operation.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy=0, done=0, result=0; internal operand, mode, accumulator, chunk index and found flag all cleared. No done is produced afterwards for the aborted operation.
- States: IDLE, RUN.
- IDLE, edge with start=1:
  - Latch data and mode; acc=0; idx=0; found=0.
  - Go to RUN; busy=1 from this edge.
- IDLE, edge with start=0: remain in IDLE.
- RUN, each edge: process chunk idx, then idx=idx+1.
  - Mode 00: acc += number of ones in the chunk. Chunks are taken LSB-first: chunk k = bits [k*CHUNK+CHUNK-1 : k*CHUNK].
  - Mode 01: acc += CHUNK minus the ones in the chunk.
  - Mode 10: chunks are taken MSB-first. If found=0, acc += leading zeros of the chunk (CHUNK if the chunk is all zero). found is set once any chunk is nonzero. Later chunks add nothing.
  - Mode 11: same as mode 10, but chunks are taken LSB-first and trailing zeros are counted.
- RUN, edge processing the last chunk (idx=NCH-1):
  - result = final acc.
  - done=1 for exactly one cycle; busy=0; state goes to IDLE.
- Latency: start sampled at edge E0; done high and result valid in the cycle after edge E_NCH. Busy is high for exactly NCH cycles.
- Fixed latency in every mode; there is no early exit.
- done is 0 in every other cycle.
- result holds its value until the next completion or reset.
- start while busy=1: ignored. The latched operand and mode are unaffected, and the request is not queued.
- start in the done cycle: busy=0 at that point, so the request is accepted (back-to-back operation).
- All-zero operand: CLZ = CTZ = WIDTH. Count zeros = WIDTH; count ones = 0.
- All-ones operand: count ones = WIDTH; CLZ = CTZ = 0.
- Arithmetic: the accumulator is RW bits wide, unsigned, and never overflows because the maximum count is WIDTH.
- Chunk popcount is pure combinational within the cycle. No multi-cycle paths.

Test Plan (WIDTH=32, CHUNK=8, NCH=4 unless stated):
- Mode 00, data=0xFFFFFFFF, start pulse → busy high for 4 cycles; then done pulse of exactly 1 cycle with result=32. A second run with data=0x80000001 → result=2.
- Mode 01, data=0x000000F0 → result=28. Mode 01, data=0 → result=32.
- Mode 10: data=0x00010000 → result=15; data=0 → result=32; data=0x80000000 → result=0.
- Mode 11: data=0x80000000 → result=31; data=0x00000100 → result=8.
- Handshake:
  - Start mode 00 with data=0x0000000F. One cycle later, raise start with data=0xFFFFFFFF; it is ignored and result=4.
  - Raise start in the done cycle with mode 11, data=0x10 → accepted; the second done arrives 4 cycles later with result=4.
- Reset: assert reset during the 2nd RUN cycle → busy, done and result go to 0 immediately (asynchronously); no done follows. Repeat the mode 10 cases with CHUNK=1 (NCH=32) and CHUNK=32 (NCH=1) → same results, busy lasting 32 cycles and 1 cycle respectively.
